// File: rtl/mux8_arb_pkg.sv
// Shared types and constants for the 8-way round-robin single-bit mux arbiter.
package mux8_arb_pkg;

    localparam int unsigned N_REQ = 8;

    typedef logic [2:0] sel_t;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

endpackage

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Rotating-priority picker: first asserted request at or after ptr, wrapping 7->0.
module rr_pick8
    import mux8_arb_pkg::*;
(
    input  logic [7:0] req,
    input  sel_t       ptr,
    output logic       found,
    output sel_t       idx
);

    sel_t cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = ptr + sel_t'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 single-bit path; grants are held until
// the owner drops its request or MAX_HOLD cycles elapse.
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CNT_W    = 8
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] in,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       valid,
    output logic       q
);

    arb_state_t       state_q;
    sel_t             ptr_q;
    sel_t             sel_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       grant_q;
    logic             valid_q;

    logic             pick_found;
    sel_t             pick_idx;
    logic [7:0]       grant_d;
    logic             release_d;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign grant_d   = 8'b0000_0001 << pick_idx;
    assign release_d = !req[sel_q] || (cnt_q == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q   <= '0;
                    grant_q <= '0;
                    valid_q <= 1'b0;
                    if (pick_found) begin
                        state_q <= GRANT;
                        sel_q   <= pick_idx;
                        grant_q <= grant_d;
                        valid_q <= 1'b1;
                        ptr_q   <= pick_idx + sel_t'(1);
                    end
                end
                GRANT: begin
                    // Release re-searches immediately so the next owner starts
                    // without a bubble; the old owner only wins if alone.
                    if (release_d) begin
                        cnt_q <= '0;
                        if (pick_found) begin
                            sel_q   <= pick_idx;
                            grant_q <= grant_d;
                            valid_q <= 1'b1;
                            ptr_q   <= pick_idx + sel_t'(1);
                        end else begin
                            state_q <= IDLE;
                            grant_q <= '0;
                            valid_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    valid_q <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign valid = valid_q;
    assign q     = valid_q & in[sel_q];

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter against a cycle-level ownership model.
module tb_mux8_rr_arbiter;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] in_v;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       valid;
    logic       q;

    int checks = 0;
    int passed = 0;

    // Model: current owner (-1 when idle), cycles held so far, next search start.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;

    mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .in    (in_v),
        .grant (grant),
        .sel   (sel),
        .valid (valid),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
    endtask

    task automatic model_step(input logic [7:0] r);
        int nxt;
        if (m_owner < 0 || !r[m_owner] || m_held == MAX_HOLD) begin
            nxt = -1;
            for (int k = 0; k < 8; k++) begin
                if (nxt < 0 && r[(m_ptr + k) % 8]) nxt = (m_ptr + k) % 8;
            end
            m_owner = nxt;
            m_held  = (nxt >= 0) ? 1 : 0;
            if (nxt >= 0) m_ptr = (nxt + 1) % 8;
        end else begin
            m_held = m_held + 1;
        end
    endtask

    // {grant, valid, sel (only meaningful while valid), q}
    function automatic logic [12:0] exp_vec();
        logic [7:0] g;
        logic [2:0] s;
        logic       qq;
        g  = '0;
        s  = '0;
        qq = 1'b0;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            s  = 3'(m_owner);
            qq = in_v[m_owner];
        end
        return {g, (m_owner >= 0), s, qq};
    endfunction

    function automatic logic [12:0] act_vec();
        return {grant, valid, (valid ? sel : 3'd0), q};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(req);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst  = 1'b1;
        req  = '0;
        in_v = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (grant !== 8'h00 || valid !== 1'b0 || sel !== 3'd0 || q !== 1'b0)
            $display("FAIL reset_state: grant=%h valid=%b sel=%0d q=%b, want 00/0/0/0", grant, valid, sel, q);
        else passed++;
    endtask

    task automatic test_single();
        apply_reset();
        req = 8'h20;
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int t = 0; t < 2; t++) begin
                in_v = (t == 0) ? 8'h20 : 8'hDF;
                #1;
                checks++;
                if (act_vec() !== exp_vec() || grant !== 8'h20 || q !== in_v[5])
                    $display("FAIL single_grant: got %h want %h (grant=%h q=%b)", act_vec(), exp_vec(), grant, q);
                else passed++;
            end
        end
        req = 8'h00;
        tick();
        checks++;
        if (act_vec() !== exp_vec() || valid !== 1'b0 || grant !== 8'h00)
            $display("FAIL single_release: got %h want %h", act_vec(), exp_vec());
        else passed++;
    endtask

    task automatic test_round_robin();
        logic [7:0] want;
        apply_reset();
        req  = 8'h81;
        in_v = 8'h80;
        for (int c = 0; c < 12; c++) begin
            tick();
            want = ((c / 4) % 2 == 0) ? 8'h01 : 8'h80;
            checks++;
            if (act_vec() !== exp_vec() || grant !== want || valid !== 1'b1)
                $display("FAIL round_robin cyc %0d: grant=%h valid=%b want grant=%h valid=1", c, grant, valid, want);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        req = 8'h40;
        tick();
        req = 8'h00;
        tick();
        req = 8'h41;
        tick();
        checks++;
        if (act_vec() !== exp_vec() || grant !== 8'h01 || sel !== 3'd0)
            $display("FAIL wrap_winner: grant=%h sel=%0d want grant=01 sel=0", grant, sel);
        else passed++;
    endtask

    task automatic test_timeout_lone();
        apply_reset();
        req  = 8'h04;
        in_v = 8'h04;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (act_vec() !== exp_vec() || sel !== 3'd2 || valid !== 1'b1)
                $display("FAIL timeout_lone cyc %0d: sel=%0d valid=%b want sel=2 valid=1", c, sel, valid);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        req  = 8'h12;
        in_v = 8'h10;
        tick();
        tick();
        checks++;
        if (act_vec() !== exp_vec() || grant !== 8'h02)
            $display("FAIL handoff_owner1: grant=%h want 02", grant);
        else passed++;
        req = 8'h10;
        tick();
        checks++;
        if (act_vec() !== exp_vec() || grant !== 8'h10 || q !== 1'b1)
            $display("FAIL handoff_owner4: grant=%h q=%b want grant=10 q=1", grant, q);
        else passed++;
        in_v = 8'h00;
        #1;
        checks++;
        if (q !== 1'b0)
            $display("FAIL handoff_q_follow: q=%b want 0", q);
        else passed++;
    endtask

    task automatic test_reset_mid_grant();
        apply_reset();
        req  = 8'h08;
        in_v = 8'hFF;
        tick();
        tick();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (grant !== 8'h00 || valid !== 1'b0 || sel !== 3'd0 || q !== 1'b0)
            $display("FAIL reset_mid_grant: grant=%h valid=%b sel=%0d q=%b want 00/0/0/0", grant, valid, sel, q);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        req = 8'h08;
        tick();
        checks++;
        if (act_vec() !== exp_vec() || grant !== 8'h08)
            $display("FAIL reset_regrant: grant=%h want 08", grant);
        else passed++;
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom) & 8'($urandom);
            in_v = 8'($urandom);
            tick();
            checks++;
            if (act_vec() !== exp_vec())
                $display("FAIL random cyc %0d: got %h want %h (req=%h)", c, act_vec(), exp_vec(), req);
            else passed++;
        end
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        in_v = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_timeout_lone();
        test_back_to_back();
        test_reset_mid_grant();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
